td4x_core: RTL

//  Parametrised TD4-class CPU with its own program store, loader/readback port, run/step control and
//  one hardware breakpoint. Generalises the 4-bit TD4 datapath to DATA_W bits and 2**ADDR_W words.

---
 rtl/td4x_prog_if.sv | 23 ++
 rtl/td4x_core.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/td4x_prog_if.sv
// Program-store loader/readback port of the TD4-class core.
// The loader (master) drives address and write data; the core (slave) returns the addressed word.
interface td4x_prog_if #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] prog_addr;
    logic [3:0]        prog_op;
    logic [DATA_W-1:0] prog_imm;
    logic              prog_we;
    logic [3:0]        rd_op;
    logic [DATA_W-1:0] rd_imm;

    modport master (
        output prog_addr, prog_op, prog_imm, prog_we,
        input  rd_op, rd_imm
    );

    modport slave (
        input  prog_addr, prog_op, prog_imm, prog_we,
        output rd_op, rd_imm
    );
endinterface

// File: rtl/td4x_core.sv
// Parametrised TD4-class CPU: flop program store, run/step/load/read control, one breakpoint.
// Executes one instruction per enabled cycle from mem[pc].
module td4x_core #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        mode,
    input  logic              step,
    td4x_prog_if.slave        prog,
    input  logic              bp_en,
    input  logic [ADDR_W-1:0] bp_addr,
    input  logic [DATA_W-1:0] io_in,
    output logic [DATA_W-1:0] reg_a,
    output logic [DATA_W-1:0] reg_b,
    output logic [DATA_W-1:0] io_out,
    output logic              carry,
    output logic [ADDR_W-1:0] pc,
    output logic              halted
);
    localparam int DEPTH  = 2 ** ADDR_W;
    localparam int WORD_W = 4 + DATA_W;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b01;
    localparam logic [1:0] MODE_LOAD = 2'b10;
    localparam logic [1:0] MODE_READ = 2'b11;

    typedef enum logic [1:0] {S_HALT, S_RUN, S_STEP, S_BRK} state_e;

    typedef enum logic [3:0] {
        OP_ADD_A  = 4'b0000,
        OP_MOV_AB = 4'b0001,
        OP_IN_A   = 4'b0010,
        OP_MOV_AI = 4'b0011,
        OP_MOV_BA = 4'b0100,
        OP_ADD_B  = 4'b0101,
        OP_IN_B   = 4'b0110,
        OP_MOV_BI = 4'b0111,
        OP_OUT_B  = 4'b1001,
        OP_OUT_I  = 4'b1011,
        OP_JNC    = 4'b1110,
        OP_JMP    = 4'b1111
    } op_e;

    logic [WORD_W-1:0] mem [DEPTH];
    state_e            state, state_next;
    logic              exec;
    logic              step_s1, step_s2, step_d;
    logic              step_pulse;
    op_e               op;
    logic [DATA_W-1:0] im;
    logic [DATA_W:0]   sum_a, sum_b;

    // NOTE: the store is cleared by reset like any other state, so a reset forces a program reload.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (mode == MODE_LOAD && prog.prog_we) begin
            mem[prog.prog_addr] <= {prog.prog_op, prog.prog_imm};
        end
    end

    assign prog.rd_op  = mem[prog.prog_addr][WORD_W-1:DATA_W];
    assign prog.rd_imm = mem[prog.prog_addr][DATA_W-1:0];
    assign op          = op_e'(mem[pc][WORD_W-1:DATA_W]);
    assign im          = mem[pc][DATA_W-1:0];
    assign sum_a       = {1'b0, reg_a} + {1'b0, im};
    assign sum_b       = {1'b0, reg_b} + {1'b0, im};

    // Two-flop synchroniser on the button, then a rising-edge detector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_s1 <= 1'b0;
            step_s2 <= 1'b0;
            step_d  <= 1'b0;
        end else begin
            step_s1 <= step;
            step_s2 <= step_s1;
            step_d  <= step_s2;
        end
    end

    assign step_pulse = step_s2 & ~step_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_HALT;
        else        state <= state_next;
    end

    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    always_comb begin
        state_next = state;
        exec       = 1'b0;
        if (mode == MODE_LOAD || mode == MODE_READ) begin
            state_next = S_HALT;
        end else begin
            unique case (state)
                S_HALT: state_next = (mode == MODE_RUN) ? S_RUN : S_STEP;
                S_RUN: begin
                    if (mode == MODE_STEP)               state_next = S_STEP;
                    else if (bp_en && pc == bp_addr)     state_next = S_BRK;
                    else                                 exec       = 1'b1;
                end
                S_BRK: begin
                    if (mode != MODE_RUN) begin
                        state_next = S_HALT;
                    end else if (step_pulse) begin
                        exec       = 1'b1;
                        state_next = S_RUN;
                    end
                end
                S_STEP: begin
                    if (mode == MODE_RUN) state_next = S_RUN;
                    else                  exec       = step_pulse;
                end
                default: state_next = S_HALT;
            endcase
        end
    end

    assign halted = (state == S_HALT) || (state == S_BRK);

    // NOTE: architectural state uses non-blocking assignments so every update sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a  <= '0;
            reg_b  <= '0;
            io_out <= '0;
            carry  <= 1'b0;
            pc     <= '0;
        end else if (exec) begin
            pc    <= pc + 1'b1;
            carry <= 1'b0;
            case (op)
                OP_ADD_A:  {carry, reg_a} <= sum_a;
                OP_ADD_B:  {carry, reg_b} <= sum_b;
                OP_MOV_AB: reg_a  <= reg_b;
                OP_MOV_BA: reg_b  <= reg_a;
                OP_MOV_AI: reg_a  <= im;
                OP_MOV_BI: reg_b  <= im;
                OP_IN_A:   reg_a  <= io_in;
                OP_IN_B:   reg_b  <= io_in;
                OP_OUT_B:  io_out <= reg_b;
                OP_OUT_I:  io_out <= im;
                OP_JNC:    if (!carry) pc <= im[ADDR_W-1:0];
                OP_JMP:    pc <= im[ADDR_W-1:0];
                default:   ;
            endcase
        end
    end
endmodule
